add: RTL and testbench

Four-operand unsigned adder with a registered, valid/ready-handshaked output. Sums four WIDTH-bit operands into a WIDTH+2-bit result that can never overflow. Sits in the datapath as a small arithmetic leaf between a producer that presents operand sets and a consumer that accepts sums. An optional compile-time pipeline stage splits the adder tree for timing closure.

---
 rtl/add.sv | 99 +++++++++
 tb/tb_add.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/add.sv
// Four-operand unsigned adder with a valid/ready handshaked registered sum.
// Define ADD_PIPE_EN to register the pairwise sums (latency 2 instead of 1).
module add #(
    parameter int WIDTH = 6
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic             valid_i,
    output logic             ready_o,
    output logic [WIDTH+1:0] e,
    output logic             valid_o,
    input  logic             ready_i
);

    localparam int SW = WIDTH + 1;
    localparam int EW = WIDTH + 2;

    logic [SW-1:0] s_ab;
    logic [SW-1:0] s_cd;
    logic          out_ready;
    logic          stage_valid;
    logic [EW-1:0] stage_sum;

    logic [EW-1:0] e_q, e_d;
    logic          out_valid_q, out_valid_d;

    assign s_ab      = {1'b0, a} + {1'b0, b};
    assign s_cd      = {1'b0, c} + {1'b0, d};
    assign out_ready = !out_valid_q || ready_i;

`ifdef ADD_PIPE_EN
    logic [SW-1:0] ab_q, ab_d;
    logic [SW-1:0] cd_q, cd_d;
    logic          mid_valid_q, mid_valid_d;

    assign ready_o     = !mid_valid_q || out_ready;
    assign stage_valid = mid_valid_q;
    assign stage_sum   = {1'b0, ab_q} + {1'b0, cd_q};

    always_comb begin
        mid_valid_d = mid_valid_q;
        ab_d        = ab_q;
        cd_d        = cd_q;
        if (ready_o) begin
            mid_valid_d = valid_i;
            if (valid_i) begin
                ab_d = s_ab;
                cd_d = s_cd;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ab_q        <= '0;
            cd_q        <= '0;
            mid_valid_q <= 1'b0;
        end else begin
            ab_q        <= ab_d;
            cd_q        <= cd_d;
            mid_valid_q <= mid_valid_d;
        end
    end
`else
    assign ready_o     = out_ready;
    assign stage_valid = valid_i;
    assign stage_sum   = {1'b0, s_ab} + {1'b0, s_cd};
`endif

    // e only changes on a load, so it keeps its last sum once drained
    always_comb begin
        e_d         = e_q;
        out_valid_d = out_valid_q;
        if (out_ready) begin
            out_valid_d = stage_valid;
            if (stage_valid) begin
                e_d = stage_sum;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            e_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            e_q         <= e_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign e       = e_q;
    assign valid_o = out_valid_q;

endmodule

// File: tb/tb_add.sv
// Self-checking bench for add: queue-based reference model of sums,
// latency and capacity, driven by directed and random steps.
module tb_add;

    localparam int W = 6;
`ifdef ADD_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic           clk_i;
    logic           rst_n_i;
    logic [W-1:0]   a, b, c, d;
    logic           valid_i;
    logic           ready_o;
    logic [W+1:0]   e;
    logic           valid_o;
    logic           ready_i;

    int q_val[$];
    int q_avl[$];
    int cyc;
    int checks;
    int errors;
    int last_e;
    logic acc;

    add #(.WIDTH(W)) dut (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .a       (a),
        .b       (b),
        .c       (c),
        .d       (d),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .e       (e),
        .valid_o (valid_o),
        .ready_i (ready_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d at cycle %0d",
                   tag, obs, exp, cyc);
        end
    endtask

    task automatic rand_ops();
        a = W'($urandom);
        b = W'($urandom);
        c = W'($urandom);
        d = W'($urandom);
    endtask

    task automatic set_ops(input int v0, input int v1,
                           input int v2, input int v3);
        a = W'(v0);
        b = W'(v1);
        c = W'(v2);
        d = W'(v3);
    endtask

    // Called 1 time unit after a rising edge; samples mid-cycle.
    task automatic step();
        logic exp_valid;
        logic exp_ready;
        #3;
        exp_valid = (q_val.size() > 0) && (cyc >= q_avl[0]);
        exp_ready = (q_val.size() < LAT) || (exp_valid && ready_i);
        chk("ready_o", {31'b0, ready_o}, {31'b0, exp_ready});
        chk("valid_o", {31'b0, valid_o}, {31'b0, exp_valid});
        if (exp_valid)
            chk("e_sum", 32'(e), 32'(q_val[0]));
        else
            chk("e_hold", 32'(e), 32'(last_e));
        acc = valid_i && exp_ready;
        if (exp_valid && ready_i) begin
            last_e = q_val.pop_front();
            void'(q_avl.pop_front());
        end
        if (acc) begin
            q_val.push_back(int'(a) + int'(b) + int'(c) + int'(d));
            q_avl.push_back(cyc + LAT);
        end
        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    task automatic send(input int v0, input int v1,
                        input int v2, input int v3);
        int n;
        set_ops(v0, v1, v2, v3);
        valid_i = 1'b1;
        n = 0;
        acc = 1'b0;
        while (!acc && n < 20) begin
            step();
            n++;
        end
        if (!acc) chk("send_timeout", 32'd0, 32'd1);
        valid_i = 1'b0;
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_e"}, 32'(e), 32'd0);
        chk({tag, "_valid_o"}, {31'b0, valid_o}, 32'd0);
        chk({tag, "_ready_o"}, {31'b0, ready_o}, 32'd1);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        cyc     = 0;
        last_e  = 0;
        acc     = 1'b0;
        rst_n_i = 1'b0;
        valid_i = 1'b1;
        ready_i = 1'b0;
        rand_ops();
        #1;
        reset_checks("reset_hold");
        repeat (3) begin
            @(posedge clk_i);
            #1;
            rand_ops();
            valid_i = 1'($urandom);
            ready_i = 1'($urandom);
        end
        reset_checks("reset_end");
        rst_n_i = 1'b1;
        valid_i = 1'b0;
        ready_i = 1'b1;
        step();

        // Ramp at full throughput
        for (int i = 1; i <= 30; i++) begin
            set_ops(i, i, i, i);
            valid_i = 1'b1;
            step();
        end
        valid_i = 1'b0;
        repeat (3) step();

        // Extremes
        send(63, 63, 63, 63);
        send(63, 0, 1, 2);
        send(0, 0, 0, 0);
        repeat (3) step();

        // Backpressure behind a sum of 40
        send(10, 10, 10, 10);
        ready_i = 1'b0;
        valid_i = 1'b1;
        set_ops(11, 11, 11, 11);
        for (int k = 0; k < LAT + 5; k++) begin
            step();
            if (acc) set_ops(12 + k, 1, 2, 3);
        end
        ready_i = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            if (acc) set_ops(k, 20, 30, 40);
        end
        valid_i = 1'b0;
        repeat (4) step();

        // Random traffic; operands held while not accepted
        rand_ops();
        valid_i = 1'($urandom);
        for (int k = 0; k < 300; k++) begin
            ready_i = ($urandom_range(0, 3) != 0);
            step();
            if (!(valid_i && !acc)) begin
                rand_ops();
                valid_i = 1'($urandom);
            end
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        repeat (4) step();

        // Reset mid-stream while a sum is stalled at the output
        ready_i = 1'b0;
        valid_i = 1'b1;
        rand_ops();
        repeat (3) begin
            step();
            if (acc) rand_ops();
        end
        chk("pre_reset_valid_o", {31'b0, valid_o}, 32'd1);
        #2;
        rst_n_i = 1'b0;
        #1;
        reset_checks("mid_reset");
        q_val.delete();
        q_avl.delete();
        last_e = 0;
        repeat (2) begin
            @(posedge clk_i);
            #1;
            rand_ops();
        end
        reset_checks("mid_reset_hold");
        rst_n_i = 1'b1;
        valid_i = 1'b0;
        ready_i = 1'b1;
        repeat (4) step();
        send(1, 2, 3, 4);
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
